iguana_vga_dither: RTL and testbench
====================================

IGUANA_VGA_DITHER -- requirements
Module: iguana_vga_dither

Interface
REQ-001 SHALL have parameter InRedWidth, default 5, Cheshire VGA red width.
REQ-002 SHALL have parameter InGreenWidth, default 6, Cheshire VGA green width.
REQ-003 SHALL have parameter InBlueWidth, default 5, Cheshire VGA blue width.
REQ-004 SHALL have parameters OutRedWidth / OutGreenWidth / OutBlueWidth, defaults 3 / 3 / 2, pad widths.
REQ-005 SHALL have parameter SyncActiveHigh, default 0, sync polarity for both syncs.
REQ-006 Ports: clk_i  in  1  system clock; one clock, all logic on rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 pix_en_i  in  1  pixel strobe; input pixel valid this cycle.
REQ-009 dith_en_i  in  1  1 = dither, 0 = plain truncation.
REQ-010 hsync_i, vsync_i  in  1 each  Cheshire VGA syncs.
REQ-011 red_i / green_i / blue_i  in  In*Width  Cheshire pixel.
REQ-012 hsync_o, vsync_o  out  1 each  registered syncs to pads.
REQ-013 red_o / green_o / blue_o  out  Out*Width  reduced pixel to pads.

Function
REQ-014 Per channel, D = InWidth - OutWidth; 1 <= D <= 4 SHALL be elaborated and checked; other values are an elaboration error.
REQ-015 All outputs SHALL be registered; latency exactly 1 pix_en_i strobe; syncs delayed identically to colour.
REQ-016 Without pix_en_i, all outputs and counters SHALL hold.
REQ-017 Counters: x[1:0], y[1:0], frame[1:0]; all wrap 3->0 modulo 4.
REQ-018 On pix_en_i with hsync_i inactive, x SHALL increment; on hsync assertion edge, x SHALL clear to 0 and y SHALL increment.
REQ-019 On vsync assertion edge, y SHALL clear to 0 and frame SHALL increment; if hsync and vsync edges coincide, vsync wins (y = 0).
REQ-020 Edges SHALL be detected against previous sampled sync, sampled only on pix_en_i.
REQ-021 Threshold T = top D bits of 4-bit Bayer B[y][x], B = {0,8,2,10; 12,4,14,6; 3,11,1,9; 15,7,13,5}.
REQ-022 Dither: out = in[W-1:D] + (in[D-1:0] > T), saturated at 2^OutWidth - 1.
REQ-023 dith_en_i = 0: out = in[W-1:D]; counters still run.
REQ-024 While either sync active, colour outputs SHALL be 0.

Reset
REQ-025 rst_i SHALL clear x, y, frame, colour outputs to 0 and set syncs and sync history to inactive level.
REQ-026 Reset mid-frame SHALL restart counters at 0; first post-reset pixel uses B[0][0]; no output glitch other than inactive syncs during reset.

Configuration
REQ-027 Macro IGUANA_VGA_DITHER_TEMPORAL_EN defined: Bayer column index SHALL be (x + frame) mod 4, rotating pattern per frame.
REQ-028 Macro undefined: column index SHALL be x; frame counter SHALL not be built, and frame SHALL read 0 everywhere.

Structure
REQ-029 Bayer matrix constant and in/out width constants SHALL live in iguana_pkg, reusing VgaOut*Width.
REQ-030 One sub-module iguana_vga_dither_chan (combinational add/compare/saturate, width-parameterised) SHALL be instantiated three times; counters and registers live in the top.

Verification
REQ-031 Reset, x=0,y=0, red_i=6, dith_en_i=1 -> red_o=2 after one strobe (T=0, low bits 2>0).
REQ-032 x=1,y=0, red_i=6 -> red_o=1 (T=2, 2>2 false); dith_en_i=0, red_i=6 -> red_o=1.
REQ-033 red_i=31, green_i=63, blue_i=31 at any x,y -> red_o=7, green_o=7, blue_o=3 (saturation).
REQ-034 Drive 4 hsync pulses, then vsync with hsync together -> y sequence 1,2,3,0 then y=0; frame increments once.
REQ-035 Hold pix_en_i=0 for 10 cycles mid-line -> outputs and x unchanged; asserting rst_i mid-line -> outputs 0, syncs inactive next cycle.
REQ-036 With IGUANA_VGA_DITHER_TEMPORAL_EN, frame=1, x=0,y=0, red_i=6 -> T from B[0][1]=8 gives top2 2, red_o=1; without macro -> red_o=2.

Source files
------------

// File: rtl/iguana_pkg.sv
// Shared constants for the Iguana VGA pad path: Cheshire-side and pad-side
// colour widths plus the 4x4 ordered-dither (Bayer) matrix.
package iguana_pkg;

   localparam int unsigned VgaInRedWidth    = 5;
   localparam int unsigned VgaInGreenWidth  = 6;
   localparam int unsigned VgaInBlueWidth   = 5;
   localparam int unsigned VgaOutRedWidth   = 3;
   localparam int unsigned VgaOutGreenWidth = 3;
   localparam int unsigned VgaOutBlueWidth  = 2;

   // Bayer rows {0,8,2,10; 12,4,14,6; 3,11,1,9; 15,7,13,5}, nibble (row*4+col)
   localparam logic [63:0] BayerFlat = 64'h5D7F_91B3_6E4C_A280;

   // Look up B[row][col] from the flattened matrix
   function automatic logic [3:0] bayer_at(input logic [1:0] row, input logic [1:0] col);
      return BayerFlat[{row, col, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/iguana_vga_dither_chan.sv
// One colour channel: truncate to OutWidth bits, optionally round up when the
// dropped bits exceed the Bayer threshold, and saturate at full scale.
module iguana_vga_dither_chan #(
   parameter int unsigned InWidth  = 5,
   parameter int unsigned OutWidth = 3
) (
   input  logic [InWidth-1:0]  pix,
   input  logic [3:0]          bayer,
   input  logic                dith_en,
   output logic [OutWidth-1:0] res_c
);

   localparam int unsigned D = InWidth - OutWidth;

   // Only 1..4 dropped bits can be matched against a 4-bit Bayer entry
   if (InWidth <= OutWidth || D > 4) begin : g_bad_width
      $error("iguana_vga_dither_chan: InWidth - OutWidth must be 1..4");
   end

   logic [D-1:0]        thresh;
   logic [D-1:0]        low;
   logic [OutWidth-1:0] base;
   logic [OutWidth:0]   sum;

   assign thresh = D'(bayer >> (4 - D));
   assign low    = pix[D-1:0];
   assign base   = pix[InWidth-1:D];

   // Add the dither bit and clamp on carry-out
   always_comb begin
      sum   = {1'b0, base};
      if (dith_en && (low > thresh)) begin
         sum = sum + (OutWidth+1)'(1);
      end
      res_c = sum[OutWidth] ? {OutWidth{1'b1}} : sum[OutWidth-1:0];
   end

endmodule

// File: rtl/iguana_vga_dither.sv
// Cheshire VGA to pad colour reducer with ordered dithering.
// Optional feature: define IGUANA_VGA_DITHER_TEMPORAL_EN to rotate the Bayer
// column by a 2-bit frame counter so the pattern shifts every frame.
module iguana_vga_dither
   import iguana_pkg::*;
#(
   parameter int unsigned InRedWidth     = VgaInRedWidth,
   parameter int unsigned InGreenWidth   = VgaInGreenWidth,
   parameter int unsigned InBlueWidth    = VgaInBlueWidth,
   parameter int unsigned OutRedWidth    = VgaOutRedWidth,
   parameter int unsigned OutGreenWidth  = VgaOutGreenWidth,
   parameter int unsigned OutBlueWidth   = VgaOutBlueWidth,
   parameter bit          SyncActiveHigh = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     pix_en_i,
   input  logic                     dith_en_i,
   input  logic                     hsync_i,
   input  logic                     vsync_i,
   input  logic [InRedWidth-1:0]    red_i,
   input  logic [InGreenWidth-1:0]  green_i,
   input  logic [InBlueWidth-1:0]   blue_i,
   output logic                     hsync_o,
   output logic                     vsync_o,
   output logic [OutRedWidth-1:0]   red_o,
   output logic [OutGreenWidth-1:0] green_o,
   output logic [OutBlueWidth-1:0]  blue_o
);

   localparam logic SyncIdle = SyncActiveHigh ? 1'b0 : 1'b1;

   logic [1:0] x;
   logic [1:0] y;
   logic [1:0] col;
   logic       hs_prev;
   logic       vs_prev;
   logic       hs_act;
   logic       vs_act;
   logic       hs_edge;
   logic       vs_edge;
   logic [3:0] bayer;

   logic [OutRedWidth-1:0]   red_c;
   logic [OutGreenWidth-1:0] green_c;
   logic [OutBlueWidth-1:0]  blue_c;

   assign hs_act  = (hsync_i == SyncActiveHigh);
   assign vs_act  = (vsync_i == SyncActiveHigh);
   assign hs_edge = hs_act && (hs_prev != SyncActiveHigh);
   assign vs_edge = vs_act && (vs_prev != SyncActiveHigh);

`ifdef IGUANA_VGA_DITHER_TEMPORAL_EN
   logic [1:0] frame;

   // Frame counter advances on each vsync assertion edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame <= 2'd0;
      end else if (pix_en_i && vs_edge) begin
         frame <= frame + 2'd1;
      end
   end

   assign col = x + frame;
`else
   assign col = x;
`endif

   assign bayer = bayer_at(y, col);

   // Screen position counters and sync history, advanced only on pixel strobes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x       <= 2'd0;
         y       <= 2'd0;
         hs_prev <= SyncIdle;
         vs_prev <= SyncIdle;
      end else if (pix_en_i) begin
         hs_prev <= hsync_i;
         vs_prev <= vsync_i;
         if (hs_edge) begin
            x <= 2'd0;
            y <= y + 2'd1;
         end else if (!hs_act) begin
            x <= x + 2'd1;
         end
         // vsync edge overrides the line increment
         if (vs_edge) begin
            y <= 2'd0;
         end
      end
   end

   iguana_vga_dither_chan #(.InWidth(InRedWidth), .OutWidth(OutRedWidth)) u_red (
      .pix     (red_i),
      .bayer   (bayer),
      .dith_en (dith_en_i),
      .res_c   (red_c)
   );

   iguana_vga_dither_chan #(.InWidth(InGreenWidth), .OutWidth(OutGreenWidth)) u_green (
      .pix     (green_i),
      .bayer   (bayer),
      .dith_en (dith_en_i),
      .res_c   (green_c)
   );

   iguana_vga_dither_chan #(.InWidth(InBlueWidth), .OutWidth(OutBlueWidth)) u_blue (
      .pix     (blue_i),
      .bayer   (bayer),
      .dith_en (dith_en_i),
      .res_c   (blue_c)
   );

   // Pad registers: colour blanked while either sync is active, syncs delayed alike
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hsync_o <= SyncIdle;
         vsync_o <= SyncIdle;
         red_o   <= '0;
         green_o <= '0;
         blue_o  <= '0;
      end else if (pix_en_i) begin
         hsync_o <= hsync_i;
         vsync_o <= vsync_i;
         if (hs_act || vs_act) begin
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
         end else begin
            red_o   <= red_c;
            green_o <= green_c;
            blue_o  <= blue_c;
         end
      end
   end

endmodule

// File: tb/tb_iguana_vga_dither.sv
// Randomised bench for iguana_vga_dither against an arithmetic reference model.
// Honours IGUANA_VGA_DITHER_TEMPORAL_EN the same way the design does.
module tb_iguana_vga_dither;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       pix_en_i = 1'b0;
   logic       dith_en_i = 1'b0;
   logic       hsync_i = 1'b1;
   logic       vsync_i = 1'b1;
   logic [4:0] red_i = '0;
   logic [5:0] green_i = '0;
   logic [4:0] blue_i = '0;
   logic       hsync_o;
   logic       vsync_o;
   logic [2:0] red_o;
   logic [2:0] green_o;
   logic [1:0] blue_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   int   bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
   int   mx, my, mf;
   logic mph, mpv;
   int   er, eg, eb;
   logic ehs, evs;

   always #5 clk = ~clk;

   iguana_vga_dither dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .pix_en_i  (pix_en_i),
      .dith_en_i (dith_en_i),
      .hsync_i   (hsync_i),
      .vsync_i   (vsync_i),
      .red_i     (red_i),
      .green_i   (green_i),
      .blue_i    (blue_i),
      .hsync_o   (hsync_o),
      .vsync_o   (vsync_o),
      .red_o     (red_o),
      .green_o   (green_o),
      .blue_o    (blue_o)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Ordered-dither reduction of one channel, from the arithmetic definition
   function automatic int reduce(input int v, input int inw, input int outw,
                                 input int b, input bit dith);
      int d, q, r, t, top;
      d   = inw - outw;
      q   = v / (1 << d);
      r   = v % (1 << d);
      t   = b / (1 << (4 - d));
      top = (1 << outw) - 1;
      if (dith && r > t) q = q + 1;
      if (q > top) q = top;
      return q;
   endfunction

   // Advance the model by one clock using the currently driven inputs
   task automatic model_tick();
      int c, b;
      bit blank, hedge, vedge;
      if (rst_i) begin
         mx = 0; my = 0; mf = 0; mph = 1'b1; mpv = 1'b1;
         er = 0; eg = 0; eb = 0; ehs = 1'b1; evs = 1'b1;
      end else if (pix_en_i) begin
`ifdef IGUANA_VGA_DITHER_TEMPORAL_EN
         c = (mx + mf) % 4;
`else
         c = mx;
`endif
         b     = bay[my][c];
         blank = (hsync_i == 1'b0) || (vsync_i == 1'b0);
         er    = blank ? 0 : reduce(int'(red_i),   5, 3, b, dith_en_i);
         eg    = blank ? 0 : reduce(int'(green_i), 6, 3, b, dith_en_i);
         eb    = blank ? 0 : reduce(int'(blue_i),  5, 2, b, dith_en_i);
         ehs   = hsync_i;
         evs   = vsync_i;
         hedge = (hsync_i == 1'b0) && (mph == 1'b1);
         vedge = (vsync_i == 1'b0) && (mpv == 1'b1);
         if (hedge) begin
            mx = 0;
            my = (my + 1) % 4;
         end else if (hsync_i == 1'b1) begin
            mx = (mx + 1) % 4;
         end
         if (vedge) begin
            my = 0;
            mf = (mf + 1) % 4;
         end
         mph = hsync_i;
         mpv = vsync_i;
      end
   endtask

   // Drive one cycle, step the model, and compare all outputs after the edge
   task automatic cycle(input bit rst, input bit en, input bit dith, input bit hs,
                        input bit vs, input int r, input int g, input int bl);
      @(negedge clk);
      rst_i     = rst;
      pix_en_i  = en;
      dith_en_i = dith;
      hsync_i   = hs;
      vsync_i   = vs;
      red_i     = 5'(r);
      green_i   = 6'(g);
      blue_i    = 5'(bl);
      model_tick();
      @(posedge clk);
      #1;
      check("red",   8'(red_o),   8'(er));
      check("green", 8'(green_o), 8'(eg));
      check("blue",  8'(blue_o),  8'(eb));
      check("hsync", 8'(hsync_o), 8'(ehs));
      check("vsync", 8'(vsync_o), 8'(evs));
   endtask

   task automatic rand_cycle(input bit en);
      cycle(1'b0, en, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
            $urandom_range(0, 31) != 0, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
   endtask

   initial begin
      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 31, 63, 31);
      check("rst_red",   8'(red_o),   8'd0);
      check("rst_hsync", 8'(hsync_o), 8'd1);
      check("rst_vsync", 8'(vsync_o), 8'd1);

      // First pixel uses B[0][0]; then x=1 threshold; then plain truncation
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 0, 0);
      check("x0y0_dith", 8'(red_o), 8'd2);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 0, 0);
      check("x1y0_dith", 8'(red_o), 8'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6, 0, 0);
      check("trunc", 8'(red_o), 8'd1);

      // Full-scale inputs saturate
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 31, 63, 31);
      check("sat_red",   8'(red_o),   8'd7);
      check("sat_green", 8'(green_o), 8'd7);
      check("sat_blue",  8'(blue_o),  8'd3);

      // Strobe held low: everything holds
      for (int i = 0; i < 10; i++) rand_cycle(1'b0);
      check("hold_red", 8'(red_o), 8'd7);

      // Four line pulses, then a frame pulse coinciding with a line pulse
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 20, 9);
         cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, int'($urandom_range(0, 31)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
      end
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, 0, 0);
      check("blank_red", 8'(red_o), 8'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 0, 0);
`ifdef IGUANA_VGA_DITHER_TEMPORAL_EN
      check("frame1_x0y0", 8'(red_o), 8'd1);
`else
      check("frame1_x0y0", 8'(red_o), 8'd2);
`endif

      // Randomised traffic, with occasional strobe gaps
      for (int i = 0; i < 3000; i++) begin
         rand_cycle($urandom_range(0, 3) != 0);
      end

      // Reset in the middle of a line
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 31, 63, 31);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 31, 63, 31);
      check("midrst_red",   8'(red_o),   8'd0);
      check("midrst_green", 8'(green_o), 8'd0);
      check("midrst_blue",  8'(blue_o),  8'd0);
      check("midrst_hsync", 8'(hsync_o), 8'd1);
      check("midrst_vsync", 8'(vsync_o), 8'd1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 0, 0);
      check("post_rst_x0y0", 8'(red_o), 8'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
